// File: rtl/idx_array_pkg.sv
// Shared definitions for indexed_array_store: Option tag encoding, clear FSM
// states and small helpers used for sizing and tag selection.
package idx_array_pkg;

  localparam logic OPT_TAG_SOME = 1'b0;
  localparam logic OPT_TAG_NONE = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  function automatic logic opt_tag(input logic hit);
    return hit ? OPT_TAG_SOME : OPT_TAG_NONE;
  endfunction

  // Counter/address width that stays legal for a single-entry array.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/idx_array_clear_seq.sv
// Clear sequencer: on a clear pulse in IDLE, sweeps entries 0..DEPTH-1 one per
// cycle and reports busy while the sweep is in progress.
module idx_array_clear_seq
  import idx_array_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  output logic             busy_o,
  output logic             clr_en_o,
  output logic [CNT_W-1:0] clr_idx_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  clr_state_t       r_state;
  clr_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    busy_o      = 1'b0;
    clr_en_o    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_i) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        busy_o   = 1'b1;
        clr_en_o = 1'b1;
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign clr_idx_o = r_cnt;

endmodule

// File: rtl/indexed_array_store.sv
// DEPTH x WIDTH store with tag-checked registered reads returning an Option word.
// Define IDX_ARRAY_BYPASS_EN for write-first forwarding on same-edge write/read.
module indexed_array_store
  import idx_array_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3,
  parameter int IDX_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_index_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] index_i,
  input  logic             clear_i,
  output logic [WIDTH:0]   output__,
  output logic             rd_valid_o,
  output logic             busy_o
);

  localparam int           AW        = cnt_width(DEPTH);
  localparam logic [WIDTH:0] NONE_WORD = {OPT_TAG_NONE, {WIDTH{1'b0}}};

  function automatic logic [WIDTH:0] opt_word(input logic tag, input logic [WIDTH-1:0] payload);
    return {tag, (tag == OPT_TAG_SOME) ? payload : {WIDTH{1'b0}}};
  endfunction

  // Full-width unsigned compare so high index bits can never alias a low entry.
  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < (IDX_W + 1)'(DEPTH);
  endfunction

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [WIDTH:0]   r_out;
  logic             r_rd_valid;

  logic             w_busy;
  logic             w_clr_en;
  logic [AW-1:0]    w_clr_idx;
  logic             w_wr_ok;
  logic             w_rd_hit;
  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_rd_addr;
  logic [WIDTH:0]   w_rd_word;

  idx_array_clear_seq #(
    .DEPTH (DEPTH),
    .CNT_W (AW)
  ) u_clear_seq (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (clear_i),
    .busy_o    (w_busy),
    .clr_en_o  (w_clr_en),
    .clr_idx_o (w_clr_idx)
  );

  assign w_wr_addr = wr_index_i[AW-1:0];
  assign w_rd_addr = index_i[AW-1:0];
  assign w_wr_ok   = wr_en_i && !w_busy && in_range(wr_index_i);
  // Reads during a sweep report None even for entries not yet reached.
  assign w_rd_hit  = !w_busy && in_range(index_i) && r_valid[w_rd_addr];

  always_comb begin
    w_rd_word = opt_word(opt_tag(w_rd_hit), r_data[w_rd_addr]);
`ifdef IDX_ARRAY_BYPASS_EN
    if (w_wr_ok && (wr_index_i == index_i)) begin
      w_rd_word = opt_word(OPT_TAG_SOME, wr_data_i);
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid    <= '0;
      r_out      <= NONE_WORD;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_clr_en) begin
        r_valid[w_clr_idx] <= 1'b0;
      end else if (w_wr_ok) begin
        r_valid[w_wr_addr] <= 1'b1;
      end
      r_rd_valid <= rd_en_i;
      if (rd_en_i) begin
        r_out <= w_rd_word;
      end
    end
  end

  // Payload storage is not reset; stale contents are hidden by the valid vector.
  always_ff @(posedge clk_i) begin
    if (w_clr_en) begin
      r_data[w_clr_idx] <= '0;
    end else if (w_wr_ok) begin
      r_data[w_wr_addr] <= wr_data_i;
    end
  end

  assign output__   = r_out;
  assign rd_valid_o = r_rd_valid;
  assign busy_o     = w_busy;

endmodule

// File: tb/tb_indexed_array_store.sv
// Self-checking bench for indexed_array_store (WIDTH=16, DEPTH=3, IDX_W=16):
// vector table plus hand-written clear, hold and mid-sweep reset sequences.
module tb_indexed_array_store;

  localparam logic [16:0] NONE = 17'h10000;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [15:0] wr_index_i = '0;
  logic [15:0] wr_data_i = '0;
  logic        rd_en_i = 1'b0;
  logic [15:0] index_i = '0;
  logic        clear_i = 1'b0;
  logic [16:0] output__;
  logic        rd_valid_o;
  logic        busy_o;

  int total = 0;
  int bad = 0;
  logic [16:0] sb[$];

  typedef struct {
    logic        wr;
    logic [15:0] widx;
    logic [15:0] wd;
    logic        rd;
    logic [15:0] ridx;
    logic [16:0] exp;
  } vec_t;
  vec_t vecs[$];

  indexed_array_store #(.WIDTH(16), .DEPTH(3), .IDX_W(16)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wr_en_i    (wr_en_i),
    .wr_index_i (wr_index_i),
    .wr_data_i  (wr_data_i),
    .rd_en_i    (rd_en_i),
    .index_i    (index_i),
    .clear_i    (clear_i),
    .output__   (output__),
    .rd_valid_o (rd_valid_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [16:0] some(input logic [15:0] d);
    return {1'b0, d};
  endfunction

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, then compare what the DUT produced for it.
  task automatic step(input logic wr, input logic [15:0] widx, input logic [15:0] wd,
                      input logic rd, input logic [15:0] ridx, input logic clr,
                      input logic [16:0] exp, input string nm);
    wr_en_i = wr; wr_index_i = widx; wr_data_i = wd;
    rd_en_i = rd; index_i = ridx; clear_i = clr;
    if (rd) sb.push_back(exp);
    @(posedge clk_i);
    #1;
    wr_en_i = 1'b0; rd_en_i = 1'b0; clear_i = 1'b0;
    chk({nm, "_vld"}, {16'd0, rd_valid_o}, {16'd0, rd});
    if ((rd_valid_o || rd) && sb.size() > 0) chk(nm, output__, sb.pop_front());
  endtask

  task automatic rd(input logic [15:0] idx, input logic [16:0] exp, input string nm);
    step(1'b0, 16'd0, 16'd0, 1'b1, idx, 1'b0, exp, nm);
  endtask

  task automatic wr(input logic [15:0] idx, input logic [15:0] d, input string nm);
    step(1'b1, idx, d, 1'b0, 16'd0, 1'b0, NONE, nm);
  endtask

  initial begin
    logic [16:0] same_edge_exp;
`ifdef IDX_ARRAY_BYPASS_EN
    same_edge_exp = some(16'd99);
`else
    same_edge_exp = some(16'd13);
`endif
    vecs.push_back(vec_t'{1'b0, 16'd0,    16'd0,  1'b1, 16'd1,    NONE});
    vecs.push_back(vec_t'{1'b0, 16'd0,    16'd0,  1'b1, 16'd3,    NONE});
    vecs.push_back(vec_t'{1'b0, 16'd0,    16'd0,  1'b1, 16'hFFFF, NONE});
    vecs.push_back(vec_t'{1'b1, 16'd0,    16'd11, 1'b0, 16'd0,    NONE});
    vecs.push_back(vec_t'{1'b1, 16'd1,    16'd12, 1'b0, 16'd0,    NONE});
    vecs.push_back(vec_t'{1'b1, 16'd2,    16'd13, 1'b0, 16'd0,    NONE});
    vecs.push_back(vec_t'{1'b0, 16'd0,    16'd0,  1'b1, 16'd0,    some(16'd11)});
    vecs.push_back(vec_t'{1'b0, 16'd0,    16'd0,  1'b1, 16'd1,    some(16'd12)});
    vecs.push_back(vec_t'{1'b0, 16'd0,    16'd0,  1'b1, 16'd2,    some(16'd13)});
    vecs.push_back(vec_t'{1'b1, 16'd5,    16'd77, 1'b1, 16'd0,    some(16'd11)});
    vecs.push_back(vec_t'{1'b0, 16'd0,    16'd0,  1'b1, 16'd1,    some(16'd12)});
    vecs.push_back(vec_t'{1'b0, 16'd0,    16'd0,  1'b1, 16'd4,    NONE});
    vecs.push_back(vec_t'{1'b0, 16'd0,    16'd0,  1'b1, 16'h8000, NONE});
    vecs.push_back(vec_t'{1'b1, 16'd2,    16'd99, 1'b1, 16'd2,    same_edge_exp});
    vecs.push_back(vec_t'{1'b0, 16'd0,    16'd0,  1'b1, 16'd2,    some(16'd99)});

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_out", output__, NONE);
    chk("rst_vld", {16'd0, rd_valid_o}, 17'd0);
    chk("rst_busy", {16'd0, busy_o}, 17'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    foreach (vecs[i])
      step(vecs[i].wr, vecs[i].widx, vecs[i].wd, vecs[i].rd, vecs[i].ridx, 1'b0,
           vecs[i].exp, $sformatf("vec%0d", i));

    // Output holds with rd_en_i low.
    rd(16'd1, some(16'd12), "hold_rd");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0, NONE, $sformatf("hold%0d", k));
      chk($sformatf("hold_out%0d", k), output__, some(16'd12));
    end

    // Clear sweep with loaded entries: busy for exactly 3 cycles.
    step(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b1, NONE, "clr_start");
    chk("clr_busy0", {16'd0, busy_o}, 17'd1);
    rd(16'd1, NONE, "clr_rd1");
    chk("clr_busy1", {16'd0, busy_o}, 17'd1);
    step(1'b1, 16'd0, 16'd44, 1'b1, 16'd2, 1'b0, NONE, "clr_wr_rd2");
    chk("clr_busy2", {16'd0, busy_o}, 17'd1);
    rd(16'd0, NONE, "clr_rd0");
    chk("clr_busy3", {16'd0, busy_o}, 17'd0);
    rd(16'd0, NONE, "post_clr0");
    rd(16'd1, NONE, "post_clr1");
    rd(16'd2, NONE, "post_clr2");

    // Reload, then reset in the middle of a sweep.
    wr(16'd0, 16'd21, "rl_wr0");
    wr(16'd1, 16'd22, "rl_wr1");
    rd(16'd0, some(16'd21), "rl_rd0");
    step(1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b1, NONE, "rst_clr_start");
    rd(16'd0, NONE, "rst_clr_rd");
    chk("rst_mid_busy_pre", {16'd0, busy_o}, 17'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("rst_mid_busy", {16'd0, busy_o}, 17'd0);
    chk("rst_mid_vld", {16'd0, rd_valid_o}, 17'd0);
    chk("rst_mid_out", output__, NONE);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    rd(16'd0, NONE, "after_rst0");
    rd(16'd1, NONE, "after_rst1");
    rd(16'd2, NONE, "after_rst2");

    chk("sb_empty", 17'(sb.size()), 17'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
